match_pe_scoreboard: RTL and testbench
======================================

MATCH_PE_SCOREBOARD -- requirements
Module: match_pe_scoreboard

Interface
REQ-001 Parameter SCOREBOARD_ENTRY_INDEX, default 2; log2 of the entry count (N = 2^SCOREBOARD_ENTRY_INDEX).
REQ-002 Parameter TAG_W, default 8; width of the job tag.
REQ-003 Widths from parameters.vh:
- ADDR = `ADDR_WIDTH
- PEW = `MATCH_PE_WIDTH
- LEN = `MAX_MATCH_LEN_LOG2+1
- MAXLEN = 2^`MAX_MATCH_LEN_LOG2
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  new match job offered
- job_ready  out  1  free entry available
- job_tag  in  TAG_W  opaque job identifier
- job_head_addr  in  ADDR  head start address
- job_history_addr  in  ADDR  history start address
- pe_valid  out  1  request to the match PE pipeline (always accepted)
- pe_idx  out  SCOREBOARD_ENTRY_INDEX  entry issuing the request
- pe_last  out  1  final beat for this job
- pe_head_addr  out  ADDR  head address of the beat
- pe_history_addr  out  ADDR  history address of the beat
- rsp_valid  in  1  PE result valid
- rsp_last  in  1  echo of pe_last
- rsp_idx  in  SCOREBOARD_ENTRY_INDEX  echo of pe_idx
- rsp_match_len  in  LEN  matched bytes in the beat (0..PEW)
- res_valid  out  1  completed job available
- res_ready  in  1  consumer accepts the result
- res_tag  out  TAG_W  tag of the completed job
- res_match_len  out  LEN  total match length (0..MAXLEN)

Function
REQ-006 Each entry SHALL hold: state (FREE, ISSUE, WAIT, DONE), tag, head address, history address, accumulated length.
REQ-007 Entries SHALL be allocated round-robin at alloc_ptr and retired in order at retire_ptr; both pointers wrap modulo N.
REQ-008 job_ready SHALL be 1 exactly when entry[alloc_ptr] is FREE, decoded from registered state with no same-cycle bypass from retirement.
REQ-009 On job_valid&&job_ready the entry SHALL load tag, addresses and len=0, enter ISSUE, and alloc_ptr SHALL increment.
REQ-010 Issue arbitration SHALL run every cycle and select the oldest ISSUE entry, searching from retire_ptr upward.
REQ-011 On a grant the pe_* outputs SHALL be registered (pe_valid high the cycle after the grant edge) and the entry SHALL enter WAIT; pe_valid SHALL be 0 in cycles without a grant.
REQ-012 pe_last SHALL be 1 when len+PEW >= MAXLEN at grant time.
REQ-013 When rsp_valid is high, the entry at rsp_idx SHALL take len' = min(len+rsp_match_len, MAXLEN) and then:
- if rsp_match_len==PEW, rsp_last==0 and len'<MAXLEN: add PEW to both addresses (wrapping modulo 2^ADDR) and return to ISSUE;
- otherwise: enter DONE.
REQ-014 A response whose idx entry is not in WAIT SHALL be ignored; the bench flags it as an error.
REQ-015 res_valid SHALL be 1 exactly when entry[retire_ptr] is DONE; res_tag and res_match_len SHALL be driven combinationally from that entry.
REQ-016 On res_valid&&res_ready the entry SHALL become FREE and retire_ptr SHALL increment.
REQ-017 While res_valid=1 and res_ready=0, res_tag and res_match_len SHALL remain stable.
REQ-018 Later entries reaching DONE SHALL wait behind the head entry; results SHALL leave in job acceptance order.
REQ-019 Allocation, one grant, one response and one retirement SHALL all be permitted in the same cycle; each touches a distinct entry or distinct state transition.
REQ-020 A response that returns an entry to ISSUE SHALL make it eligible for grant no earlier than the following cycle.

Reset
REQ-021 Asynchronous reset SHALL, including mid-operation, set:
- all entries FREE;
- alloc_ptr=retire_ptr=0;
- pe_valid=0, pe_last=0, res_valid=0;
- job_ready=1 once rst_n is high.
REQ-022 Payload registers (addresses, tag, len, pe addresses) need no reset value; pe_valid and entry states SHALL reset.

Verification (PEW=16, MAXLEN=64, N=4)
REQ-023 Reset check: assert rst_n low mid-job, then release. Required: job_ready=1, pe_valid=0, res_valid=0, and no stale result appears.
REQ-024 Single beat: job tag=0x11 with head=0x100 and hist=0x40; respond len 5. Required: one request with pe_last=0, then res_tag=0x11 and res_match_len=5.
REQ-025 Extension: respond 16, 16, 3. Required: three requests at head 0x100, 0x110, 0x120; res_match_len=35.
REQ-026 Max length: respond 16 four times. Required: the 4th request carries pe_last=1; res_match_len=64; no 5th request.
REQ-027 Ordering and backpressure:
- Stimulus: jobs A and B; B completes first; res_ready=0 for 3 cycles.
- Required: A is emitted before B; outputs stay stable while stalled.
REQ-028 Full condition: 4 jobs outstanding; then retire one.
- Required: job_ready=0 while all 4 are outstanding.
- Required: job_ready=1 in the cycle after the retire edge, and the next job is allocated into entry 0.

Source files
------------

// File: rtl/match_pe_scoreboard.sv
// match_pe_scoreboard: tracks up to N in-flight match jobs, issues PEW-byte beats to the match PE and retires results in order
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 6
`endif

module match_pe_scoreboard #(
   parameter int SCOREBOARD_ENTRY_INDEX = 2,
   parameter int TAG_W = 8,
   localparam int ADDR = `ADDR_WIDTH,
   localparam int PEW = `MATCH_PE_WIDTH,
   localparam int LEN = `MAX_MATCH_LEN_LOG2 + 1,
   localparam int MAXLEN = 1 << `MAX_MATCH_LEN_LOG2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              job_valid,
   output logic                              job_ready,
   input  logic [TAG_W-1:0]                  job_tag,
   input  logic [ADDR-1:0]                   job_head_addr,
   input  logic [ADDR-1:0]                   job_history_addr,
   output logic                              pe_valid,
   output logic [SCOREBOARD_ENTRY_INDEX-1:0] pe_idx,
   output logic                              pe_last,
   output logic [ADDR-1:0]                   pe_head_addr,
   output logic [ADDR-1:0]                   pe_history_addr,
   input  logic                              rsp_valid,
   input  logic                              rsp_last,
   input  logic [SCOREBOARD_ENTRY_INDEX-1:0] rsp_idx,
   input  logic [LEN-1:0]                    rsp_match_len,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [TAG_W-1:0]                  res_tag,
   output logic [LEN-1:0]                    res_match_len
);
   localparam int N = 1 << SCOREBOARD_ENTRY_INDEX;
   localparam int IW = SCOREBOARD_ENTRY_INDEX;
   localparam logic [1:0] S_FREE = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q [N], state_d [N];
   logic [TAG_W-1:0] tag_q [N], tag_d [N];
   logic [ADDR-1:0]  head_q [N], head_d [N], hist_q [N], hist_d [N];
   logic [LEN-1:0]   len_q [N], len_d [N];
   logic [IW-1:0]    alloc_ptr_q, alloc_ptr_d, retire_ptr_q, retire_ptr_d;
   logic             pe_valid_q, pe_valid_d, pe_last_q, pe_last_d;
   logic [IW-1:0]    pe_idx_q, pe_idx_d;
   logic [ADDR-1:0]  pe_head_q, pe_head_d, pe_hist_q, pe_hist_d;
   logic             gnt_found;
   logic [IW-1:0]    gnt_idx, cand;
   logic [LEN:0]     gnt_sum, rsp_sum;
   logic             rsp_ok, rsp_more;

   assign job_ready = state_q[alloc_ptr_q] == S_FREE;
   assign res_valid = state_q[retire_ptr_q] == S_DONE;
   assign res_tag = tag_q[retire_ptr_q];
   assign res_match_len = len_q[retire_ptr_q];
   assign pe_valid = pe_valid_q;
   assign pe_idx = pe_idx_q;
   assign pe_last = pe_last_q;
   assign pe_head_addr = pe_head_q;
   assign pe_history_addr = pe_hist_q;

   // scan downward so the last hit is the one closest to retire_ptr, i.e. the oldest
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx = '0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = retire_ptr_q + IW'(k);
         if (state_q[cand] == S_ISSUE) begin
            gnt_found = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign gnt_sum = {1'b0, len_q[gnt_idx]} + (LEN+1)'(PEW);
   assign rsp_sum = {1'b0, len_q[rsp_idx]} + {1'b0, rsp_match_len};
   assign rsp_ok = rsp_valid && state_q[rsp_idx] == S_WAIT;
   assign rsp_more = rsp_match_len == LEN'(PEW) && !rsp_last && rsp_sum < (LEN+1)'(MAXLEN);

   always_comb begin
      state_d = state_q;
      tag_d = tag_q;
      head_d = head_q;
      hist_d = hist_q;
      len_d = len_q;
      alloc_ptr_d = alloc_ptr_q;
      retire_ptr_d = retire_ptr_q;
      pe_valid_d = gnt_found;
      pe_idx_d = gnt_idx;
      pe_last_d = gnt_found && gnt_sum >= (LEN+1)'(MAXLEN);
      pe_head_d = head_q[gnt_idx];
      pe_hist_d = hist_q[gnt_idx];
      if (job_valid && job_ready) begin
         state_d[alloc_ptr_q] = S_ISSUE;
         tag_d[alloc_ptr_q] = job_tag;
         head_d[alloc_ptr_q] = job_head_addr;
         hist_d[alloc_ptr_q] = job_history_addr;
         len_d[alloc_ptr_q] = '0;
         alloc_ptr_d = alloc_ptr_q + IW'(1);
      end
      if (gnt_found) state_d[gnt_idx] = S_WAIT;
      if (rsp_ok) begin
         len_d[rsp_idx] = rsp_sum > (LEN+1)'(MAXLEN) ? LEN'(MAXLEN) : rsp_sum[LEN-1:0];
         state_d[rsp_idx] = rsp_more ? S_ISSUE : S_DONE;
         if (rsp_more) begin
            head_d[rsp_idx] = head_q[rsp_idx] + ADDR'(PEW);
            hist_d[rsp_idx] = hist_q[rsp_idx] + ADDR'(PEW);
         end
      end
      if (res_valid && res_ready) begin
         state_d[retire_ptr_q] = S_FREE;
         retire_ptr_d = retire_ptr_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) state_q[i] <= S_FREE;
         alloc_ptr_q <= '0;
         retire_ptr_q <= '0;
         pe_valid_q <= 1'b0;
         pe_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alloc_ptr_q <= alloc_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         pe_valid_q <= pe_valid_d;
         pe_last_q <= pe_last_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      head_q <= head_d;
      hist_q <= hist_d;
      len_q <= len_d;
      pe_idx_q <= pe_idx_d;
      pe_head_q <= pe_head_d;
      pe_hist_q <= pe_hist_d;
   end
endmodule

// File: tb/tb_match_pe_scoreboard.sv
// tb_match_pe_scoreboard: directed vectors, ordering/reset/full sequences and a randomized run against a job-level model
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 6
`endif

module tb_match_pe_scoreboard;
   localparam int IW = 2;
   localparam int N = 4;
   localparam int ADDR = `ADDR_WIDTH;
   localparam int PEW = `MATCH_PE_WIDTH;
   localparam int LEN = `MAX_MATCH_LEN_LOG2 + 1;
   localparam int MAXLEN = 1 << `MAX_MATCH_LEN_LOG2;

   logic clk, rst_n;
   logic job_valid, job_ready;
   logic [7:0] job_tag;
   logic [ADDR-1:0] job_head_addr, job_history_addr;
   logic pe_valid, pe_last;
   logic [IW-1:0] pe_idx;
   logic [ADDR-1:0] pe_head_addr, pe_history_addr;
   logic rsp_valid, rsp_last;
   logic [IW-1:0] rsp_idx;
   logic [LEN-1:0] rsp_match_len;
   logic res_valid, res_ready;
   logic [7:0] res_tag;
   logic [LEN-1:0] res_match_len;

   match_pe_scoreboard #(.SCOREBOARD_ENTRY_INDEX(IW), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
      .job_head_addr(job_head_addr), .job_history_addr(job_history_addr),
      .pe_valid(pe_valid), .pe_idx(pe_idx), .pe_last(pe_last),
      .pe_head_addr(pe_head_addr), .pe_history_addr(pe_history_addr),
      .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_idx(rsp_idx), .rsp_match_len(rsp_match_len),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_match_len(res_match_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] tag;
      logic [ADDR-1:0] head;
      logic [ADDR-1:0] hist;
      logic [2:0] n;
      logic [3:0][6:0] rsp;
      logic [3:0] last;
      logic [6:0] total;
   } vec_t;

   vec_t vecs [6];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (pe_valid) ok = 1'b1;
         else tick();
      end
      chk("pe_request_seen", ok, 1);
   endtask

   task automatic wait_res(output int extra);
      bit ok;
      ok = 1'b0;
      extra = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (res_valid) ok = 1'b1;
         else begin
            if (pe_valid) extra++;
            tick();
         end
      end
      chk("res_seen", ok, 1);
   endtask

   task automatic respond_idx(input logic [IW-1:0] idx, input logic last, input logic [LEN-1:0] l);
      rsp_valid = 1'b1;
      rsp_idx = idx;
      rsp_last = last;
      rsp_match_len = l;
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic retire();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic offer(input logic [7:0] t, input logic [ADDR-1:0] h, input logic [ADDR-1:0] y);
      job_valid = 1'b1;
      job_tag = t;
      job_head_addr = h;
      job_history_addr = y;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // job-level model for the random run: 0 needs issue, 1 awaits response, 2 done, 3 free
   int m_state [N];
   int m_len [N];
   int m_beats [N];
   logic [7:0] m_tag [N];
   logic [ADDR-1:0] m_head [N], m_hist [N];
   bit m_last [N];
   int pend [$];

   initial begin
      vec_t v;
      bit ok, jr, drain, exp_rv;
      int extra, acc, ret, occ, s, r, nl, j;
      logic [ADDR-1:0] exp_a;
      vecs[0] = '{8'h11, 16'h0100, 16'h0040, 3'd1, {7'd0, 7'd0, 7'd0, 7'd5}, 4'b0000, 7'd5};
      vecs[1] = '{8'h22, 16'h0100, 16'h0040, 3'd3, {7'd0, 7'd3, 7'd16, 7'd16}, 4'b0000, 7'd35};
      vecs[2] = '{8'h33, 16'h0100, 16'h0040, 3'd4, {7'd16, 7'd16, 7'd16, 7'd16}, 4'b1000, 7'd64};
      vecs[3] = '{8'h44, 16'hFFF8, 16'h0010, 3'd2, {7'd0, 7'd0, 7'd0, 7'd16}, 4'b0000, 7'd16};
      vecs[4] = '{8'h55, 16'h0000, 16'h0000, 3'd1, {7'd0, 7'd0, 7'd0, 7'd0}, 4'b0000, 7'd0};
      vecs[5] = '{8'h66, 16'h1230, 16'h0800, 3'd4, {7'd12, 7'd16, 7'd16, 7'd16}, 4'b1000, 7'd60};
      job_valid = 0; job_tag = 0; job_head_addr = 0; job_history_addr = 0;
      rsp_valid = 0; rsp_last = 0; rsp_idx = 0; rsp_match_len = 0; res_ready = 0;
      do_reset();
      chk("reset_job_ready", job_ready, 1);
      chk("reset_pe_valid", pe_valid, 0);
      chk("reset_res_valid", res_valid, 0);

      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         chk("vec_job_ready", job_ready, 1);
         offer(v.tag, v.head, v.hist);
         for (int k = 0; k < int'(v.n); k++) begin
            wait_pe(ok);
            if (!ok) break;
            exp_a = v.head + ADDR'(PEW * k);
            chk("vec_pe_head", pe_head_addr, exp_a);
            exp_a = v.hist + ADDR'(PEW * k);
            chk("vec_pe_hist", pe_history_addr, exp_a);
            chk("vec_pe_last", pe_last, v.last[k]);
            respond_idx(pe_idx, pe_last, v.rsp[k]);
         end
         wait_res(extra);
         chk("vec_extra_pe", extra, 0);
         chk("vec_res_tag", res_tag, v.tag);
         chk("vec_res_len", res_match_len, v.total);
         retire();
         chk("vec_res_cleared", res_valid, 0);
      end

      offer(8'hA1, 16'h0200, 16'h0010);
      offer(8'hB2, 16'h0300, 16'h0020);
      wait_pe(ok);
      chk("order_first_req", pe_head_addr, 16'h0200);
      s = pe_idx;
      tick();
      wait_pe(ok);
      chk("order_second_req", pe_head_addr, 16'h0300);
      respond_idx(pe_idx, 1'b0, 7'd5);
      chk("order_head_blocks", res_valid, 0);
      respond_idx(IW'(s), 1'b0, 7'd7);
      chk("order_a_valid", res_valid, 1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_tag", res_tag, 8'hA1);
         chk("stall_len", res_match_len, 7);
         tick();
         chk("stall_valid", res_valid, 1);
      end
      retire();
      chk("order_b_valid", res_valid, 1);
      chk("order_b_tag", res_tag, 8'hB2);
      chk("order_b_len", res_match_len, 5);
      retire();
      chk("order_empty", res_valid, 0);

      offer(8'h77, 16'h0400, 16'h0050);
      wait_pe(ok);
      respond_idx(pe_idx, pe_last, 7'd16);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pe_valid", pe_valid, 0);
      chk("async_rst_res_valid", res_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_job_ready", job_ready, 1);
      chk("rst_pe_valid", pe_valid, 0);
      chk("rst_res_valid", res_valid, 0);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         if (pe_valid || res_valid) extra++;
         tick();
      end
      chk("rst_no_stale", extra, 0);

      acc = 0;
      for (int c = 0; c < 16; c++) begin
         job_valid = acc < 4;
         job_tag = 8'hA0 + 8'(acc);
         job_head_addr = ADDR'(acc << 8);
         rsp_valid = pe_valid;
         rsp_idx = pe_idx;
         rsp_last = pe_last;
         rsp_match_len = 7'd1;
         if (acc == 4) chk("full_job_ready", job_ready, 0);
         jr = job_valid && job_ready;
         tick();
         if (jr) acc++;
      end
      job_valid = 0;
      rsp_valid = 0;
      chk("full_accepted", acc, 4);
      chk("full_still_blocked", job_ready, 0);
      chk("full_head_tag", res_tag, 8'hA0);
      retire();
      chk("ready_after_retire", job_ready, 1);
      offer(8'hB0, 16'h0700, 16'h0070);
      wait_pe(ok);
      chk("realloc_entry0", pe_idx, 0);
      respond_idx(pe_idx, pe_last, 7'd2);
      for (int t = 1; t <= 4; t++) begin
         chk("full_drain_valid", res_valid, 1);
         chk("full_drain_tag", res_tag, t < 4 ? 8'hA0 + 8'(t) : 8'hB0);
         retire();
      end

      do_reset();
      for (int i = 0; i < N; i++) m_state[i] = 3;
      acc = 0;
      ret = 0;
      for (int c = 0; c < 4000; c++) begin
         drain = c >= 3000;
         if (drain && acc == ret) break;
         occ = acc - ret;
         chk("rnd_job_ready", job_ready, occ < N);
         exp_rv = occ > 0 && m_state[ret % N] == 2;
         chk("rnd_res_valid", res_valid, exp_rv);
         if (exp_rv && res_valid) begin
            chk("rnd_res_tag", res_tag, m_tag[ret % N]);
            chk("rnd_res_len", res_match_len, m_len[ret % N]);
         end
         if (pe_valid) begin
            s = pe_idx;
            chk("rnd_pe_expected", m_state[s] == 0, 1);
            if (m_state[s] == 0) begin
               exp_a = m_head[s] + ADDR'(PEW * m_beats[s]);
               chk("rnd_pe_head", pe_head_addr, exp_a);
               exp_a = m_hist[s] + ADDR'(PEW * m_beats[s]);
               chk("rnd_pe_hist", pe_history_addr, exp_a);
               m_last[s] = m_len[s] + PEW >= MAXLEN;
               chk("rnd_pe_last", pe_last, m_last[s]);
               m_state[s] = 1;
               pend.push_back(s);
            end
         end
         rsp_valid = 1'b0;
         if (pend.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
            j = $urandom_range(0, pend.size() - 1);
            s = pend[j];
            pend.delete(j);
            r = $urandom_range(0, 3) != 0 ? PEW : $urandom_range(0, PEW);
            rsp_valid = 1'b1;
            rsp_idx = IW'(s);
            rsp_last = m_last[s];
            rsp_match_len = LEN'(r);
            nl = m_len[s] + r > MAXLEN ? MAXLEN : m_len[s] + r;
            m_len[s] = nl;
            if (r == PEW && !m_last[s] && nl < MAXLEN) begin
               m_beats[s]++;
               m_state[s] = 0;
            end else m_state[s] = 2;
         end
         res_ready = drain || $urandom_range(0, 1) == 1;
         if (exp_rv && res_ready) begin
            m_state[ret % N] = 3;
            ret++;
         end
         job_valid = !drain && $urandom_range(0, 2) != 0;
         job_tag = 8'($urandom);
         job_head_addr = ADDR'($urandom);
         job_history_addr = ADDR'($urandom);
         if (job_valid && occ < N) begin
            s = acc % N;
            m_state[s] = 0;
            m_tag[s] = job_tag;
            m_head[s] = job_head_addr;
            m_hist[s] = job_history_addr;
            m_len[s] = 0;
            m_beats[s] = 0;
            acc++;
         end
         tick();
      end
      rsp_valid = 0;
      job_valid = 0;
      res_ready = 0;
      chk("rnd_drain_complete", acc - ret, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
